// File: rtl/lpif_dstrm_protid_arb.sv
// lpif_dstrm_protid_arb: packet-level round-robin arbiter onto one LPIF dstrm channel.
// Tags each flit with the owner's protid and registers it onto dstrm_* (1-cycle latency).
// Ports: clk_wr/rst_wr (async, active-high), link_active, cfg_protid[2i+:2],
//   req_valid/req_last/req_data/req_ready per requester, dstrm_trdy in,
//   dstrm_valid/dvalid/protid/data out, arb_grant (one-hot owner), err_burst, err_abort.
// Option: LPIF_ARB_PROTID_SWITCH_IDLE_EN adds a SWITCH cycle when the protid changes.
module lpif_dstrm_protid_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          link_active,
  input  logic [2*NUM_REQ-1:0]          cfg_protid,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          dstrm_trdy,
  output logic                          dstrm_valid,
  output logic                          dstrm_dvalid,
  output logic [1:0]                    dstrm_protid,
  output logic [DATA_WIDTH-1:0]         dstrm_data,
  output logic [NUM_REQ-1:0]            arb_grant,
  output logic                          err_burst,
  output logic                          err_abort
);

  localparam int IW = $clog2(NUM_REQ);
  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
    SWITCH,
`endif
    BUSY
  } state_t;

  state_t                  state, state_nx;
  idx_t                    grant, rr_ptr, win;
  logic                    win_ok;
  logic [1:0]              win_pid, cur_pid;
  logic [7:0]              burst_cnt;
  logic                    sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    busy, rdy, acc, burst_hit;
  logic [NUM_REQ-1:0]      grant_oh;
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
  logic [1:0]              prev_pid;
`endif

  // First valid requester after rr_ptr, with wrap.
  always_comb begin
    win_ok  = 1'b0;
    win     = '0;
    win_pid = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_ok && req_valid[j] &&
            j == (int'(rr_ptr) + i) % NUM_REQ) begin
          win_ok  = 1'b1;
          win     = idx_t'(j);
          win_pid = cfg_protid[2*j +: 2];
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant == idx_t'(j)) begin
        sel_valid = req_valid[j];
        sel_last  = req_last[j];
        sel_data  = req_data[DATA_WIDTH*j +: DATA_WIDTH];
      end
    end
  end

  assign busy      = (state == BUSY);
  assign rdy       = busy & link_active & (~dstrm_valid | dstrm_trdy);
  assign acc       = rdy & sel_valid;
  assign burst_hit = acc & ~sel_last &
                     (burst_cnt == 8'(MAX_BURST - 1));
  assign grant_oh  = NUM_REQ'(1) << grant;
  assign arb_grant = busy ? grant_oh : '0;
  assign req_ready = rdy ? grant_oh : '0;
  assign dstrm_dvalid = dstrm_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (link_active && win_ok) begin
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
          state_nx = (win_pid != prev_pid) ? SWITCH : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
      SWITCH: state_nx = BUSY;
`endif
      BUSY: begin
        if (!link_active)
          state_nx = IDLE;
        else if (acc && (sel_last || burst_hit))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state     <= IDLE;
      rr_ptr    <= idx_t'(NUM_REQ - 1);
      grant     <= '0;
      cur_pid   <= '0;
      burst_cnt <= '0;
      err_burst <= 1'b0;
      err_abort <= 1'b0;
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
      prev_pid  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        grant     <= win;
        rr_ptr    <= win;
        cur_pid   <= win_pid;
        burst_cnt <= '0;
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
        prev_pid  <= win_pid;
`endif
      end else if (acc) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (burst_hit)
        err_burst <= 1'b1;
      if (busy && !link_active)
        err_abort <= 1'b1;
    end
  end

  // Output flit register; a link drop flushes it.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      dstrm_valid  <= 1'b0;
      dstrm_protid <= '0;
      dstrm_data   <= '0;
    end else if (!link_active) begin
      dstrm_valid  <= 1'b0;
      dstrm_protid <= '0;
      dstrm_data   <= '0;
    end else if (acc) begin
      dstrm_valid  <= 1'b1;
      dstrm_protid <= cur_pid;
      dstrm_data   <= sel_data;
    end else if (dstrm_trdy) begin
      dstrm_valid  <= 1'b0;
      dstrm_protid <= '0;
      dstrm_data   <= '0;
    end
  end

endmodule

// File: tb/tb_lpif_dstrm_protid_arb.sv
// tb_lpif_dstrm_protid_arb: randomized + directed bench with a behavioural model.
// Model tracks owner/rotation/burst/output slot; literal checks pin key scenarios.
module tb_lpif_dstrm_protid_arb;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int MB = 8;
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
  localparam int SWGAP = 2;
`else
  localparam int SWGAP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_wr = 1'b1;
  logic            link_active = 1'b0;
  logic            dstrm_trdy = 1'b0;
  logic [2*N-1:0]  cfg_protid = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [DW*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready, arb_grant;
  logic            dstrm_valid, dstrm_dvalid, err_burst, err_abort;
  logic [1:0]      dstrm_protid;
  logic [DW-1:0]   dstrm_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lpif_dstrm_protid_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk_wr(clk), .rst_wr(rst_wr), .link_active(link_active),
    .cfg_protid(cfg_protid), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .dstrm_trdy(dstrm_trdy),
    .dstrm_valid(dstrm_valid), .dstrm_dvalid(dstrm_dvalid),
    .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .arb_grant(arb_grant), .err_burst(err_burst),
    .err_abort(err_abort)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_own = -1;
  bit         m_sw = 0;
  int         m_rr = N - 1;
  int         m_cnt = 0;
  bit         m_ov = 0;
  logic [DW-1:0] m_od = '0;
  logic [1:0] m_op = '0, m_prot = '0, m_prev = '0;
  bit         m_eb = 0, m_ea = 0;
  bit         acc_q [N];

  always @(negedge clk) begin : model
    bit busy, rdy, acc, lst;
    logic [N-1:0] eg;
    if (rst_wr) begin
      m_own = -1; m_sw = 0; m_rr = N - 1; m_cnt = 0;
      m_ov = 0; m_od = '0; m_op = '0; m_prot = '0; m_prev = '0;
      m_eb = 0; m_ea = 0;
      foreach (acc_q[i]) acc_q[i] = 0;
    end
    busy = (m_own >= 0) && !m_sw;
    rdy  = busy && !rst_wr && link_active && (!m_ov || dstrm_trdy);
    eg   = busy ? (N'(1) << m_own) : '0;
    chk("arb_grant", arb_grant, eg);
    chk("req_ready", req_ready, rdy ? eg : '0);
    chk("dstrm_valid", dstrm_valid, m_ov);
    chk("dstrm_dvalid", dstrm_dvalid, m_ov);
    chk("dstrm_protid", dstrm_protid, m_op);
    chk("dstrm_data", dstrm_data, m_od);
    chk("err_burst", err_burst, m_eb);
    chk("err_abort", err_abort, m_ea);
    if (!rst_wr) begin
      acc = rdy ? req_valid[m_own] : 1'b0;
      lst = rdy ? req_last[m_own] : 1'b0;
      foreach (acc_q[i]) acc_q[i] = acc && (i == m_own);
      if (!link_active) begin
        m_ov = 0; m_od = '0; m_op = '0;
      end else if (acc) begin
        m_ov = 1; m_od = req_data[DW*m_own +: DW]; m_op = m_prot;
      end else if (dstrm_trdy) begin
        m_ov = 0; m_od = '0; m_op = '0;
      end
      if (m_own < 0) begin
        if (link_active && req_valid != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (m_own < 0 && req_valid[(m_rr + k) % N])
              m_own = (m_rr + k) % N;
          end
          m_rr = m_own;
          m_prot = cfg_protid[2*m_own +: 2];
          m_cnt = 0;
`ifdef LPIF_ARB_PROTID_SWITCH_IDLE_EN
          m_sw = (m_prot != m_prev);
          m_prev = m_prot;
`endif
        end
      end else if (m_sw) begin
        m_sw = 0;
      end else if (!link_active) begin
        m_ea = 1; m_own = -1;
      end else if (acc) begin
        m_cnt++;
        if (lst) m_own = -1;
        else if (m_cnt == MB) begin m_eb = 1; m_own = -1; end
      end
    end
  end

  // ---------------- sources ----------------
  int seq [N];
  int pos [N];
  int len [N];
  bit en  [N];
  int vprob = 100, tprob = 100, fixlen = 3, low_cnt = 0;
  bit link_cmd = 1, link_rand = 0, cfg_rand = 0;

  function automatic int newlen();
    return (fixlen > 0) ? fixlen : int'($urandom_range(1, 10));
  endfunction

  task automatic reset_src();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; pos[i] = 0; len[i] = newlen();
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc_q[i]) begin
        acc_q[i] = 0;
        seq[i]++; pos[i]++;
        if (pos[i] == len[i]) begin pos[i] = 0; len[i] = newlen(); end
      end
      req_valid[i] = en[i] && (int'($urandom_range(0, 99)) < vprob);
      req_last[i]  = (pos[i] == len[i] - 1);
      req_data[DW*i +: DW] = {8'(i), 24'(seq[i])};
    end
    dstrm_trdy = int'($urandom_range(0, 99)) < tprob;
    if (link_rand) begin
      if (low_cnt > 0) begin
        low_cnt--; link_active = 1'b0;
      end else if ($urandom_range(0, 99) < 2) begin
        low_cnt = int'($urandom_range(0, 3)); link_active = 1'b0;
      end else link_active = 1'b1;
    end else link_active = link_cmd;
    if (cfg_rand && $urandom_range(0, 99) < 5)
      cfg_protid = (2*N)'($urandom);
  endtask

  // ---------------- logging ----------------
  bit rec = 0;
  int cyc = 0;
  int fc[$];
  logic [DW-1:0] fd[$];
  logic [1:0] fp[$];

  task automatic step();
    @(negedge clk); #1;
    if (rec && dstrm_valid) begin
      fc.push_back(cyc); fd.push_back(dstrm_data);
      fp.push_back(dstrm_protid);
    end
    cyc++;
    @(posedge clk); #1;
    drive();
  endtask

  task automatic record(input int n);
    fc.delete(); fd.delete(); fp.delete();
    rec = 1;
    repeat (n) step();
    rec = 0;
  endtask

  task automatic do_reset();
    rst_wr = 1'b1;
    reset_src();
    repeat (2) step();
    rst_wr = 1'b0;
  endtask

  int brk;
  logic [DW-1:0] d;

  initial begin
    foreach (en[i]) en[i] = 1;
    reset_src();
    cfg_protid = {2'd1, 2'd2};
    @(posedge clk); #1;
    drive();
    repeat (2) step();
    chk("rst_valid", dstrm_valid, 0);
    chk("rst_dvalid", dstrm_dvalid, 0);
    chk("rst_data", dstrm_data, 0);
    chk("rst_protid", dstrm_protid, 0);
    chk("rst_grant", arb_grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_eb", err_burst, 0);
    chk("rst_ea", err_abort, 0);
    rst_wr = 1'b0;

    // alternating grants, req0 protid 2, req1 protid 1
    record(30);
    chk("alt_nflits", fd.size() >= 12, 1);
    for (int k = 0; k < 12 && k < fd.size(); k++) begin
      d = fd[k];
      chk("alt_src", d[31:24], (k / 3) % 2);
      chk("alt_seq", d[23:0], (k / 6) * 3 + k % 3);
      chk("alt_protid", fp[k], ((k / 3) % 2 == 0) ? 2 : 1);
      if (k % 3 == 0 && k > 0)
        chk("alt_gap", fc[k] - fc[k-1] - 1, SWGAP);
    end

    // same protid on both requesters -> single bubble
    cfg_protid = {2'd1, 2'd1};
    do_reset();
    record(30);
    chk("same_nflits", fd.size() >= 12, 1);
    for (int k = 3; k < 12 && k < fd.size(); k += 3)
      chk("same_gap", fc[k] - fc[k-1] - 1, 1);

    // burst limit: 10-flit packet, no last within MAX_BURST
    en[1] = 0; fixlen = 10;
    do_reset();
    record(40);
    chk("burst_err", err_burst, 1);
    chk("burst_nflits", fd.size() >= 10, 1);
    if (fd.size() >= 10) begin
      chk("burst_run", fc[7] - fc[0], 7);
      chk("burst_gap", fc[8] - fc[7] - 1, 1);
      d = fd[8];
      chk("burst_seq8", d[23:0], 8);
      d = fd[9];
      chk("burst_seq9", d[23:0], 9);
    end

    // link drop at flit 2 of 4
    fixlen = 4;
    do_reset();
    brk = 0;
    while (seq[0] < 2 && brk < 20) begin step(); brk++; end
    chk("abort_reach", seq[0], 2);
    link_cmd = 0; link_active = 1'b0;
    @(negedge clk); #1;
    chk("abort_rdy0", req_ready, 0);
    chk("abort_v0", dstrm_valid, 1);
    chk("abort_ea0", err_abort, 0);
    @(posedge clk); #1;
    drive();
    chk("abort_ea1", err_abort, 1);
    chk("abort_v1", dstrm_valid, 0);
    chk("abort_g1", arb_grant, 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_rdy", req_ready, 0);
      @(posedge clk); #1;
      drive();
    end
    link_cmd = 1;
    repeat (10) step();

    // reset mid-packet while req0 owns the channel
    en[1] = 1; fixlen = 3;
    do_reset();
    brk = 0;
    while (!(arb_grant == 2'b01 && dstrm_valid) && brk < 30) begin
      step(); brk++;
    end
    chk("midrst_busy", arb_grant, 2'b01);
    #1 rst_wr = 1'b1;
    #1;
    chk("midrst_valid", dstrm_valid, 0);
    chk("midrst_grant", arb_grant, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_data", dstrm_data, 0);
    step();
    rst_wr = 1'b0;
    brk = 0;
    while (arb_grant == '0 && brk < 10) begin step(); brk++; end
    chk("midrst_first", arb_grant, 2'b01);

    // randomized traffic
    vprob = 70; tprob = 70; fixlen = 0;
    link_rand = 1; cfg_rand = 1;
    do_reset();
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
